retire_shadow_tracker: RTL

- Synthesizable, parametrised shadow pipeline that follows each fetched instruction through the core's stages: fetch, issue, execute, memory and write-back, in that order.
- Carries pc, instr, decoded format and register indices alongside the core, with stall and flush support.
- At retirement it pushes a commit record into an internal FIFO drained by a valid/ready consumer: a DPI checker, trace logger or debug unit.
- Replaces fixed, stall-blind delay chains; adds consistency checking, a commit counter and overflow detection.

---
 rtl/retire_shadow_tracker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/retire_shadow_tracker.sv
`default_nettype none
// ==========================================================================
// retire_shadow_tracker : stall/flush-aware shadow of the core pipeline that
// queues one commit record per retired instruction.            rev 1.0
// ==========================================================================
module retire_shadow_tracker #(
  parameter int XLEN        = 32,
  parameter int NSTAGES     = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  input  logic [5:0]      iss_type,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            stall,
  input  logic            flush,
  input  logic            retire,
  input  logic [XLEN-1:0] wb_rd_val,
  output logic            cm_valid,
  input  logic            cm_ready,
  output logic [XLEN-1:0] cm_pc,
  output logic [31:0]     cm_instr,
  output logic [5:0]      cm_type,
  output logic [4:0]      cm_rd,
  output logic [4:0]      cm_rs1,
  output logic [4:0]      cm_rs2,
  output logic [XLEN-1:0] cm_rd_val,
  output logic [31:0]     retire_count,
  output logic            err_mismatch,
  output logic            err_overflow
);
  localparam int c_AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [5:0]      typ;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rd_val;
  } rec_t;

  logic [NSTAGES:1] valid_q, valid_d;
  logic [XLEN-1:0]  pc_q    [1:NSTAGES];
  logic [XLEN-1:0]  pc_d    [1:NSTAGES];
  logic [31:0]      instr_q [1:NSTAGES];
  logic [31:0]      instr_d [1:NSTAGES];
  // Decode arrives while the instruction sits in stage 1, so the first
  // registered copy of the decode fields lives in stage 2.
  logic [5:0]       type_q  [2:NSTAGES];
  logic [5:0]       type_d  [2:NSTAGES];
  logic [4:0]       rd_q    [2:NSTAGES];
  logic [4:0]       rd_d    [2:NSTAGES];
  logic [4:0]       rs1_q   [2:NSTAGES];
  logic [4:0]       rs1_d   [2:NSTAGES];
  logic [4:0]       rs2_q   [2:NSTAGES];
  logic [4:0]       rs2_d   [2:NSTAGES];

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    type_d  = type_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (!stall) begin
      valid_d[1] = fetch_valid;
      pc_d[1]    = fetch_pc;
      instr_d[1] = fetch_instr;
      type_d[2]  = iss_type;
      rd_d[2]    = iss_rd;
      rs1_d[2]   = iss_rs1;
      rs2_d[2]   = iss_rs2;
      for (int k = 2; k <= NSTAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        pc_d[k]    = pc_q[k-1];
        instr_d[k] = instr_q[k-1];
      end
      for (int k = 3; k <= NSTAGES; k++) begin
        type_d[k] = type_q[k-1];
        rd_d[k]   = rd_q[k-1];
        rs1_d[k]  = rs1_q[k-1];
        rs2_d[k]  = rs2_q[k-1];
      end
    end
    // The killed youngest stage must not slide into the first surviving one.
    if (flush) begin
      for (int k = 1; k <= NSTAGES; k++) begin
        if (k <= FLUSH_DEPTH || (k == FLUSH_DEPTH + 1 && !stall)) begin
          valid_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    pc_q    <= pc_d;
    instr_q <= instr_d;
    type_q  <= type_d;
    rd_q    <= rd_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
  end

  rec_t            mem_q [FIFO_DEPTH];
  logic [c_AW:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]     count_q;
  logic            err_mm_q, err_ovf_q;
  logic            w_empty, w_full, w_pop, w_commit, w_push, w_bad;
  rec_t            w_rec, w_head;

  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                    (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign w_pop    = !w_empty && cm_ready;
  assign w_commit = !stall && valid_q[NSTAGES];
  assign w_push   = w_commit && (!w_full || w_pop);
  assign w_bad    = !stall && ((retire != valid_q[NSTAGES]) ||
                    (valid_q[NSTAGES] && !$onehot(type_q[NSTAGES])));

  assign w_rec.pc     = pc_q[NSTAGES];
  assign w_rec.instr  = instr_q[NSTAGES];
  assign w_rec.typ    = type_q[NSTAGES];
  assign w_rec.rd     = rd_q[NSTAGES];
  assign w_rec.rs1    = rs1_q[NSTAGES];
  assign w_rec.rs2    = rs2_q[NSTAGES];
  assign w_rec.rd_val = (rd_q[NSTAGES] == 5'd0) ? '0 : wb_rd_val;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_mm_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_push && count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
      if (w_commit && !w_push) err_ovf_q <= 1'b1;
      if (w_bad) err_mm_q <= 1'b1;
    end
  end

  // Storage is not reset; an empty FIFO presents an all-zero record.
  assign w_head       = w_empty ? '0 : mem_q[rd_ptr_q[c_AW-1:0]];
  assign cm_valid     = !w_empty;
  assign cm_pc        = w_head.pc;
  assign cm_instr     = w_head.instr;
  assign cm_type      = w_head.typ;
  assign cm_rd        = w_head.rd;
  assign cm_rs1       = w_head.rs1;
  assign cm_rs2       = w_head.rs2;
  assign cm_rd_val    = w_head.rd_val;
  assign retire_count = count_q;
  assign err_mismatch = err_mm_q;
  assign err_overflow = err_ovf_q;

endmodule
`default_nettype wire
